// File: rtl/digit_scan_controller_if.sv
// Host-side register bus of the digit scan controller: back-buffer writes and
// the commit request/status pair.
interface digit_scan_controller_if #(
  parameter int CODE_W = 8
);
  logic              wr_en;
  logic [2:0]        wr_addr;
  logic [CODE_W-1:0] wr_data;
  logic              commit;
  logic              commit_pending;

  modport master (
    output wr_en, wr_addr, wr_data, commit,
    input  commit_pending
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, commit,
    output commit_pending
  );
endinterface

// File: rtl/digit_scan_controller.sv
// Time-multiplexes a double-buffered bank of digit codes onto a segment decoder,
// with per-slot guard blanking and leading-zero ripple blanking across slots.
//
// state   | meaning
// --------+------------------------------------------------------------------
// S_GUARD | all digits off, decoder blanked while the new code settles
// S_SHOW  | dig_en[idx] on, decoder driven with the code loaded at GUARD entry
module digit_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int CODE_W       = 8,
  parameter int PRESCALE     = 1024,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  lz_en,
  input  logic                  rbo_n_in,
  digit_scan_controller_if.slave host,
  output logic [CODE_W-1:0]     code_out,
  output logic                  rbi_n_out,
  output logic                  blank,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic                  frame_start
);

  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [IDX_W-1:0] MSD_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] SHOW_TC  = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] GUARD_TC = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic {
    S_GUARD = 1'b0,
    S_SHOW  = 1'b1
  } state_t;

  state_t            state, state_next;
  logic [IDX_W-1:0]  idx, idx_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              fresh, fresh_next;
  logic              entry;
  logic              boundary;
  logic              pending;
  logic              copy_now;
  logic              wr_ok;

  logic [CODE_W-1:0] front [NUM_DIGITS];
  logic [CODE_W-1:0] back  [NUM_DIGITS];

  // fresh marks that the next enabled edge must start a new frame from the MSD
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_GUARD;
      idx   <= MSD_IDX;
      cnt   <= '0;
      fresh <= 1'b1;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      cnt   <= cnt_next;
      fresh <= fresh_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    cnt_next   = cnt;
    fresh_next = fresh;
    entry      = 1'b0;
    boundary   = 1'b0;
    if (!enable) begin
      state_next = S_GUARD;
      idx_next   = MSD_IDX;
      cnt_next   = '0;
      fresh_next = 1'b1;
    end else if (fresh) begin
      state_next = S_GUARD;
      idx_next   = MSD_IDX;
      cnt_next   = '0;
      fresh_next = 1'b0;
      entry      = 1'b1;
    end else begin
      case (state)
        S_GUARD: begin
          if (cnt == GUARD_TC) begin
            state_next = S_SHOW;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        S_SHOW: begin
          if (cnt == SHOW_TC) begin
            state_next = S_GUARD;
            cnt_next   = '0;
            entry      = 1'b1;
            if (idx == '0) begin
              idx_next = MSD_IDX;
              boundary = 1'b1;
            end else begin
              idx_next = idx - 1'b1;
            end
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        default: begin
          state_next = S_GUARD;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_comb begin
    dig_en = '0;
    blank  = 1'b1;
    if (state == S_SHOW) begin
      dig_en[idx] = 1'b1;
      blank       = 1'b0;
    end
  end

  assign copy_now            = boundary && pending;
  assign wr_ok               = host.wr_en && (32'(host.wr_addr) < NUM_DIGITS);
  assign host.commit_pending = pending;

  // The MSD code loaded on a committing boundary bypasses front so it shows the new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        front[i] <= '0;
        back[i]  <= '0;
      end
      pending     <= 1'b0;
      code_out    <= '0;
      rbi_n_out   <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= entry && (idx_next == MSD_IDX);
      if (wr_ok) begin
        back[host.wr_addr[IDX_W-1:0]] <= host.wr_data;
      end
      if (copy_now) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          front[i] <= back[i];
        end
      end
      if (host.commit) begin
        pending <= 1'b1;
      end else if (boundary) begin
        pending <= 1'b0;
      end
      if (entry) begin
        code_out <= copy_now ? back[idx_next] : front[idx_next];
        if (idx_next == MSD_IDX) begin
          rbi_n_out <= ~lz_en;
        end else if (idx_next == '0) begin
          rbi_n_out <= 1'b1;
        end else begin
          rbi_n_out <= rbo_n_in;
        end
      end
    end
  end

endmodule
